vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the VGA timing generator: samples external hsync/vsync, recovers line/frame timing, regenerates pixel coordinates.
//  Measures line length (clk_50 cycles) and lines per frame, then declares lock; consumers (capture, overlay, test checker) use pix_x/pix_y gated by locked.
// PARAMETERS
//  HS_ACTIVE_HIGH  1     1: hs pulse is high-active; 0: low-active
//  VS_ACTIVE_HIGH  1     same for vs
//  LINE_TOL        4     allowed |line length - measured| in clk_50 cycles while locked
//  MISS_MAX        3     consecutive timing misses that drop lock
//  MIN_LINE        256   shortest line (clk_50 cycles) accepted at lock
// PORTS
//  clk_50       in   1   50 MHz clock
//  rst          in   1   reset, synchronous, active-high
//  sync_hs      in   1   external hsync, asynchronous to clk_50
//  sync_vs      in   1   external vsync, asynchronous to clk_50
//  locked       out  1   timing recovered and stable
//  line_start   out  1   1-cycle pulse at each detected hs active edge
//  frame_start  out  1   1-cycle pulse at the line start that begins a frame
//  pix_x        out  10  h_cnt[10:1] (25 MHz pixel index within line)
//  pix_y        out  10  line index within frame
//  line_len     out  11  measured line length, clk_50 cycles
//  frame_lines  out  10  measured lines per frame
// BEHAVIOUR
//  Reset: every output 0; state SEARCH; h_cnt, v_cnt, miss_cnt, vs_pend = 0. Reset mid-frame aborts to this state next cycle.
//  Input path: 2-flop synchronizer, polarity normalised per parameter, edge register. line_start asserts 3 clk_50 after an hs active edge at the pin.
//  h_cnt (11b): 0 on line_start, else +1, saturating at 2047. Saturation in any state -> SEARCH, locked=0 (signal loss).
//  vs active edge sets vs_pend. On line_start: if vs_pend or a same-cycle vs edge -> v_cnt=0, frame_start pulse, vs_pend cleared; else v_cnt+1, saturating at 1023.
//  FSM:
//   SEARCH : wait for first frame_start -> MEASURE.
//   MEASURE: each line_start latches line_len=h_cnt+1. Next frame_start latches frame_lines=v_cnt+1; if line_len>=MIN_LINE -> LOCKED, else stay in MEASURE.
//   LOCKED : locked=1. Miss = line_start with |h_cnt+1-line_len|>LINE_TOL, or frame_start with v_cnt+1 != frame_lines. A good line_start/frame_start clears miss_cnt; a miss increments it; miss_cnt==MISS_MAX -> SEARCH.
//  locked deasserts the cycle after the SEARCH transition. line_len/frame_lines hold until re-measured.
//  pix_x/pix_y always follow the counters; value undefined for consumers while locked=0.
// CONFIGURATION
//  SYNC_FILTER_EN defined: after the synchronizer, a level change is accepted only after 3 identical consecutive samples. Pulses <3 clk_50 are ignored; latency +2 (line_start 5 cycles after pin edge).
//  SYNC_FILTER_EN undefined: raw synchronized level used; any glitch is an edge.
// STRUCTURE
//  Shared constants header: counter widths (HCNT_W=11, VCNT_W=10), FSM state encodings, and the standard line/frame counts (800 px, 525 lines) used by benches.
//  Sub-module vga_sync_edge: synchronizer + optional filter + polarity + rising-edge pulse; instantiated once for hs, once for vs.
// TESTING
//  1. Assert rst 4 cycles -> all outputs 0, locked=0; no line_start for an idle input.
//  2. Standard stream, 1600 clk/line, 525 lines -> locked rises after the second frame_start; line_len=1600, frame_lines=525; pix_x spans 0..799.
//  3. While locked, one line of 1610 -> miss_cnt=1, locked held; three consecutive such lines -> locked=0.
//  4. While locked, hs held inactive -> locked=0 within 2048 cycles of the last line_start; recovery relocks after two frames.
//  5. 1-cycle hs glitch mid-line: SYNC_FILTER_EN -> no line_start; without -> extra line_start and a miss.
//  6. rst mid-frame while locked -> outputs 0 next cycle; relock follows normal SEARCH/MEASURE sequence.

Source files
------------

// File: rtl/vga_sync_decoder_pkg.sv
// vga_sync_decoder_pkg: counter widths, FSM encoding and reference timing
// shared by the sync decoder, its edge detector and benches.
package vga_sync_decoder_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

  localparam int STD_H_PIX    = 800;
  localparam int STD_LINE_CLK = 1600;
  localparam int STD_V_LINES  = 525;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic [HCNT_W-1:0] abs_diff(
    input logic [HCNT_W-1:0] a,
    input logic [HCNT_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: 2-flop synchronizer, polarity fix and active-edge pulse.
// Define SYNC_FILTER_EN to require 3 equal samples before a level change.
module vga_sync_edge #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk_50,
  input  logic rst,
  input  logic sync_i,
  output logic rise_o
);

  localparam logic IDLE_PIN = ~ACTIVE_HIGH;

  logic s1_q;
  logic s2_q;
  logic lvl;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      s1_q <= IDLE_PIN;
      s2_q <= IDLE_PIN;
    end else begin
      s1_q <= sync_i;
      s2_q <= s1_q;
    end
  end

  assign lvl = ACTIVE_HIGH ? s2_q : ~s2_q;

`ifdef SYNC_FILTER_EN
  logic h0_q;
  logic h1_q;
  logic flt_q;
  logic flt_d;
  logic all1;
  logic all0;

  assign all1 = lvl & h0_q & h1_q;
  assign all0 = ~(lvl | h0_q | h1_q);

  always_comb begin
    flt_d = flt_q;
    if (all1) begin
      flt_d = 1'b1;
    end else if (all0) begin
      flt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      h0_q  <= 1'b0;
      h1_q  <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      h0_q  <= lvl;
      h1_q  <= h0_q;
      flt_q <= flt_d;
    end
  end

  assign rise_o = all1 & ~flt_q;
`else
  logic prev_q;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
`endif

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers line/frame timing from external hsync/vsync.
// Build option SYNC_FILTER_EN selects the glitch-filtered edge detector.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter bit HS_ACTIVE_HIGH = 1'b1,
  parameter bit VS_ACTIVE_HIGH = 1'b1,
  parameter int LINE_TOL       = 4,
  parameter int MISS_MAX       = 3,
  parameter int MIN_LINE       = 256
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        sync_hs,
  input  logic        sync_vs,
  output logic        locked,
  output logic        line_start,
  output logic        frame_start,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [MW-1:0]     MMAX = MW'(MISS_MAX);
  localparam logic [HCNT_W-1:0] TOL  = HCNT_W'(LINE_TOL);
  localparam logic [HCNT_W-1:0] MINL = HCNT_W'(MIN_LINE);

  logic hs_edge;
  logic vs_edge;

  vga_sync_edge #(.ACTIVE_HIGH(HS_ACTIVE_HIGH)) u_hs (
    .clk_50 (clk_50),
    .rst    (rst),
    .sync_i (sync_hs),
    .rise_o (hs_edge)
  );

  vga_sync_edge #(.ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_vs (
    .clk_50 (clk_50),
    .rst    (rst),
    .sync_i (sync_vs),
    .rise_o (vs_edge)
  );

  state_e            state_q, state_d;
  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;
  logic              vs_pend_q, vs_pend_d;
  logic [MW-1:0]     miss_q, miss_d;
  logic [HCNT_W-1:0] line_len_q, line_len_d;
  logic [VCNT_W-1:0] frame_lines_q, frame_lines_d;
  logic              locked_q;
  logic              line_start_q;
  logic              frame_start_q;

  logic              frame_ev;
  logic              sig_lost;
  logic [HCNT_W-1:0] hlen;
  logic [VCNT_W-1:0] vlen;
  logic              line_bad;
  logic              frame_bad;

  assign frame_ev  = hs_edge & (vs_pend_q | vs_edge);
  // A line start in the same cycle revives a saturated counter.
  assign sig_lost  = (h_cnt_q == HCNT_MAX) & ~hs_edge;
  assign hlen      = h_cnt_q + 1'b1;
  assign vlen      = v_cnt_q + 1'b1;
  assign line_bad  = abs_diff(hlen, line_len_q) > TOL;
  assign frame_bad = frame_ev & (vlen != frame_lines_q);

  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    vs_pend_d = vs_pend_q;
    if (hs_edge) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != HCNT_MAX) begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
    if (hs_edge) begin
      vs_pend_d = 1'b0;
    end else if (vs_edge) begin
      vs_pend_d = 1'b1;
    end
    if (frame_ev) begin
      v_cnt_d = '0;
    end else if (hs_edge && v_cnt_q != VCNT_MAX) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_d        = miss_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    if (sig_lost) begin
      state_d = ST_SEARCH;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          if (frame_ev) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (hs_edge) begin
            line_len_d = hlen;
            if (frame_ev) begin
              frame_lines_d = vlen;
              if (hlen >= MINL) begin
                state_d = ST_LOCKED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (hs_edge) begin
            if (line_bad || frame_bad) begin
              if (miss_q + 1'b1 == MMAX) begin
                state_d = ST_SEARCH;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end else begin
              miss_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vs_pend_q     <= 1'b0;
      miss_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_pend_q     <= vs_pend_d;
      miss_q        <= miss_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      locked_q      <= (state_d == ST_LOCKED);
      line_start_q  <= hs_edge;
      frame_start_q <= frame_ev;
    end
  end

  assign locked      = locked_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pix_x       = h_cnt_q[HCNT_W-1:1];
  assign pix_y       = v_cnt_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed sync streams with a frame_start scoreboard
// plus direct checks of reset, latency, loss of lock and glitch handling.
module tb_vga_sync_decoder;

  localparam int LEN    = 800;
  localparam int LONG   = 810;
  localparam int NL     = 6;
  localparam int HS_W   = 96;
  localparam int VS_ON  = 100;
  localparam int VS_OFF = 150;
  localparam int GL_OFF = 400;
`ifdef SYNC_FILTER_EN
  localparam int LAT    = 5;
  localparam int GL_LS  = 0;
`else
  localparam int LAT    = 3;
  localparam int GL_LS  = 1;
`endif

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic        sync_hs = 1'b0;
  logic        sync_vs = 1'b0;
  logic        locked;
  logic        line_start;
  logic        frame_start;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  vga_sync_decoder dut (
    .clk_50      (clk_50),
    .rst         (rst),
    .sync_hs     (sync_hs),
    .sync_vs     (sync_vs),
    .locked      (locked),
    .line_start  (line_start),
    .frame_start (frame_start),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_len    (line_len),
    .frame_lines (frame_lines)
  );

  initial forever #10 clk_50 = ~clk_50;

  typedef struct packed {
    logic        lk;
    logic [10:0] ll;
    logic [9:0]  fl;
  } fs_t;

  fs_t sb[$];
  int  n_chk    = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  ls_count = 0;
  int  last_ls  = 0;
  int  drop_el  = -1;
  int  max_px   = 0;
  bit  px_win   = 1'b0;
  bit  done     = 1'b0;
  bit  lk_prev  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic expect_fs(input logic lk, input int ll, input int fl);
    fs_t e;
    e.lk = lk;
    e.ll = 11'(ll);
    e.fl = 10'(fl);
    sb.push_back(e);
  endtask

  task automatic mon_step();
    fs_t e;
    cyc++;
    if (line_start === 1'b1) begin
      ls_count++;
      last_ls = cyc;
    end
    if (lk_prev && locked === 1'b0) drop_el = cyc - last_ls;
    lk_prev = (locked === 1'b1);
    if (px_win && locked === 1'b1 && int'(pix_x) > max_px)
      max_px = int'(pix_x);
    if (frame_start === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fs_unexpected: frame_start with empty queue (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("fs_locked", locked, e.lk);
        chk("fs_line_len", line_len, e.ll);
        chk("fs_frame_lines", frame_lines, e.fl);
        chk("fs_pix_y", pix_y, 0);
      end
    end
  endtask

  task automatic send_line(input int len, input bit vs_on, input bit gl);
    for (int c = 0; c < len; c++) begin
      sync_hs = (c < HS_W) || (gl && c == GL_OFF);
      sync_vs = vs_on && c >= VS_ON && c < VS_OFF;
      @(negedge clk_50);
    end
  endtask

  task automatic send_frame(input int n, input int lf, input int ln,
                            input int gl, input bit vs_end);
    for (int i = 0; i < n; i++) begin
      send_line((i >= lf && i < lf + ln) ? LONG : LEN,
                vs_end && i == n - 1, i == gl);
    end
  endtask

  task automatic run();
    int k;
    int g0;
    rst = 1'b1;
    repeat (4) @(negedge clk_50);
    chk("rst_locked", locked, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_frame_lines", frame_lines, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk_50);
    chk("idle_no_line_start", ls_count, 0);

    sync_hs = 1'b1;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_50);
      if (line_start === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("line_start_latency", k, LAT);
    repeat (HS_W) @(negedge clk_50);
    sync_hs = 1'b0;
    repeat (300) @(negedge clk_50);

    send_frame(NL, -1, 0, -1, 1'b1);
    expect_fs(1'b0, 0, 0);
    send_frame(NL, -1, 0, -1, 1'b1);
    expect_fs(1'b1, LEN, NL);
    px_win = 1'b1;
    send_frame(NL, -1, 0, -1, 1'b1);
    px_win = 1'b0;
    chk("pix_x_max", max_px, LEN / 2 - 1);

    expect_fs(1'b1, LEN, NL);
    send_frame(NL, 1, 1, -1, 1'b1);
    expect_fs(1'b1, LEN, NL);
    send_frame(NL, 1, 3, -1, 1'b1);
    chk("locked_after_3_misses", locked, 0);
    expect_fs(1'b0, LEN, NL);
    send_frame(NL, -1, 0, -1, 1'b1);

    expect_fs(1'b1, LEN, NL);
    g0 = ls_count;
    send_frame(NL, -1, 0, 2, 1'b1);
    chk("glitch_line_starts", ls_count - g0, NL + GL_LS);
    expect_fs(1'b1, LEN, NL);
    send_frame(NL, -1, 0, -1, 1'b1);

    drop_el = -1;
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50);
      if (locked === 1'b0) begin
        k = 1;
        break;
      end
    end
    @(negedge clk_50);
    chk("hs_loss_unlock", k, 1);
    chk("hs_loss_drop_window", (drop_el >= 2040 && drop_el <= 2048), 1);
    repeat (100) @(negedge clk_50);
    expect_fs(1'b0, LEN, NL);
    send_frame(NL, -1, 0, -1, 1'b1);
    expect_fs(1'b1, LEN, NL);
    send_frame(3, -1, 0, -1, 1'b0);
    chk("pre_rst_locked", locked, 1);

    rst = 1'b1;
    @(negedge clk_50);
    chk("midrst_locked", locked, 0);
    chk("midrst_line_len", line_len, 0);
    chk("midrst_frame_lines", frame_lines, 0);
    chk("midrst_pix_x", pix_x, 0);
    chk("midrst_pix_y", pix_y, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk_50);
    send_frame(NL, -1, 0, -1, 1'b1);
    expect_fs(1'b0, 0, 0);
    send_frame(NL, -1, 0, -1, 1'b1);
    expect_fs(1'b1, LEN, NL);
    send_frame(NL, -1, 0, -1, 1'b1);
    repeat (50) @(negedge clk_50);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    fork
      begin
        while (!done) begin
          @(negedge clk_50);
          mon_step();
        end
      end
      begin
        run();
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
